// File: rtl/data_bus_bridge.sv
// ---------------------------------------------------------------------------
// data_bus_bridge
// Connects the M stage of the pipeline to a request/acknowledge memory bus.
// A load or store in M raises a bus request. The pipeline is stalled until
// the slave completes the access. Load data is kept in a register so that the
// M stage can consume it in the DONE state.
//
// Parameters
//   KSEG_MAP       1: kseg0/kseg1 virtual addresses (top bits 100/101) are
//                  mapped to physical addresses by clearing bits [31:29]
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_mem_en       M-stage instruction is a load or store
//   i_mem_wen[3:0] byte write strobes, 0000 = load (big-endian lanes)
//   i_mem_addr     byte address from the ALU
//   i_mem_wdata    lane-replicated store data
//   i_pipe_advance M stage moves on this cycle
//   o_mem_rdata    registered load data returned to M
//   o_stall_mem    stall request to the hazard unit
//   o_bus_req      request valid
//   o_bus_wr       1 = write, 0 = read
//   o_bus_wstrb    byte strobes
//   o_bus_addr     word-aligned physical address
//   o_bus_wdata    write data
//   i_bus_addr_ok  slave accepts the request this cycle
//   i_bus_data_ok  slave completes the access this cycle
//   i_bus_rdata    read data, valid with i_bus_data_ok
// ---------------------------------------------------------------------------
module data_bus_bridge #(
    parameter int KSEG_MAP = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_en,
    input  logic [3:0]  i_mem_wen,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic        i_pipe_advance,
    output logic [31:0] o_mem_rdata,
    output logic        o_stall_mem,
    output logic        o_bus_req,
    output logic        o_bus_wr,
    output logic [3:0]  o_bus_wstrb,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_addr_ok,
    input  logic        i_bus_data_ok,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Request fields captured when a request leaves IDLE. The address is
    // stored already mapped and word-aligned.
    logic        r_wr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem_rdata;

    logic        w_wr_in;
    logic [31:0] w_phys_addr;
    logic        w_rd_capture;
    logic        w_latch;

    // Virtual to physical translation. The low two bits are always forced to
    // zero because the bus is word addressed and the strobes select the bytes.
    function automatic logic [31:0] phys_addr(input logic [31:0] vaddr);
        logic [31:0] pa;
        pa = {vaddr[31:2], 2'b00};
        if ((KSEG_MAP != 0) && ((vaddr[31:29] == 3'b100) || (vaddr[31:29] == 3'b101))) begin
            pa[31:29] = 3'b000;
        end else begin
            pa[31:29] = vaddr[31:29];
        end
        return pa;
    endfunction

    assign w_wr_in     = |i_mem_wen;
    assign w_phys_addr = phys_addr(i_mem_addr);
    assign w_latch     = (r_state == ST_IDLE) && i_mem_en;
    assign o_mem_rdata = r_mem_rdata;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; mem_en is only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_mem_en) begin
                    if (!i_bus_addr_ok) begin
                        w_next_state = ST_REQ;
                    end else if (i_bus_data_ok) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_bus_addr_ok) begin
                    if (i_bus_data_ok) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_bus_data_ok) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (i_pipe_advance) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Bus outputs and read-capture strobe. In IDLE the request is driven
    // straight from the pipeline so that a same-cycle accept is possible.
    always_comb begin
        o_bus_req    = 1'b0;
        o_bus_wr     = r_wr;
        o_bus_wstrb  = r_wstrb;
        o_bus_addr   = r_addr;
        o_bus_wdata  = r_wdata;
        w_rd_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_bus_req    = i_mem_en & ~i_rst;
                o_bus_wr     = w_wr_in;
                o_bus_wstrb  = i_mem_wen;
                o_bus_addr   = w_phys_addr;
                o_bus_wdata  = i_mem_wdata;
                w_rd_capture = i_mem_en & i_bus_addr_ok & i_bus_data_ok & ~w_wr_in;
            end
            ST_REQ: begin
                o_bus_req    = ~i_rst;
                w_rd_capture = i_bus_addr_ok & i_bus_data_ok & ~r_wr;
            end
            ST_WAIT: begin
                o_bus_req    = 1'b0;
                w_rd_capture = i_bus_data_ok & ~r_wr;
            end
            ST_DONE: begin
                o_bus_req    = 1'b0;
                w_rd_capture = 1'b0;
            end
            default: begin
                o_bus_req    = 1'b0;
                w_rd_capture = 1'b0;
            end
        endcase
        // Reset must also release the pipeline immediately.
        o_stall_mem = i_mem_en & (r_state != ST_DONE) & ~i_rst;
    end

    // Request field latch, loaded whenever a request leaves IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= 1'b0;
            r_wstrb <= 4'b0000;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
        end else if (w_latch) begin
            r_wr    <= w_wr_in;
            r_wstrb <= i_mem_wen;
            r_addr  <= w_phys_addr;
            r_wdata <= i_mem_wdata;
        end else begin
            r_wr    <= r_wr;
            r_wstrb <= r_wstrb;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Load data register; writes and stray data_ok leave it untouched
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_rdata <= 32'h0000_0000;
        end else if (w_rd_capture) begin
            r_mem_rdata <= i_bus_rdata;
        end else begin
            r_mem_rdata <= r_mem_rdata;
        end
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        pipe_advance;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] bus_rdata;

    logic [31:0] mem_rdata, mem_rdata0;
    logic        stall, stall0;
    logic        bus_req, bus_req0;
    logic        bus_wr, bus_wr0;
    logic [3:0]  bus_wstrb, bus_wstrb0;
    logic [31:0] bus_addr, bus_addr0;
    logic [31:0] bus_wdata, bus_wdata0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] addr_nomap;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    txn_t cur;

    always #5 clk = ~clk;

    data_bus_bridge u_dut (
        .i_clk(clk), .i_rst(rst), .i_mem_en(mem_en), .i_mem_wen(mem_wen),
        .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata), .i_pipe_advance(pipe_advance),
        .o_mem_rdata(mem_rdata), .o_stall_mem(stall), .o_bus_req(bus_req),
        .o_bus_wr(bus_wr), .o_bus_wstrb(bus_wstrb), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .i_bus_addr_ok(addr_ok), .i_bus_data_ok(data_ok),
        .i_bus_rdata(bus_rdata)
    );

    data_bus_bridge #(.KSEG_MAP(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_mem_en(mem_en), .i_mem_wen(mem_wen),
        .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata), .i_pipe_advance(pipe_advance),
        .o_mem_rdata(mem_rdata0), .o_stall_mem(stall0), .o_bus_req(bus_req0),
        .o_bus_wr(bus_wr0), .o_bus_wstrb(bus_wstrb0), .o_bus_addr(bus_addr0),
        .o_bus_wdata(bus_wdata0), .i_bus_addr_ok(addr_ok), .i_bus_data_ok(data_ok),
        .i_bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] a0, input logic wr,
                        input logic [3:0] st, input logic [31:0] wd, input logic [31:0] rd);
        txn_t t;
        t.addr = a; t.addr_nomap = a0; t.wr = wr; t.wstrb = st; t.wdata = wd; t.rdata = rd;
        sb.push_back(t);
    endtask

    // Request-phase fields of both instances against the current transaction
    task automatic req_fields(input string tag);
        chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
        chk({tag, "_addr"}, bus_addr, cur.addr);
        chk({tag, "_wr"}, {31'd0, bus_wr}, {31'd0, cur.wr});
        chk({tag, "_wstrb"}, {28'd0, bus_wstrb}, {28'd0, cur.wstrb});
        chk({tag, "_wdata"}, bus_wdata, cur.wdata);
        chk({tag, "_req0"}, {31'd0, bus_req0}, 32'd1);
        chk({tag, "_stall0"}, {31'd0, stall0}, 32'd1);
        chk({tag, "_addr0"}, bus_addr0, cur.addr_nomap);
        chk({tag, "_wr0"}, {31'd0, bus_wr0}, {31'd0, cur.wr});
        chk({tag, "_wstrb0"}, {28'd0, bus_wstrb0}, {28'd0, cur.wstrb});
        chk({tag, "_wdata0"}, bus_wdata0, cur.wdata);
    endtask

    task automatic start_txn(input string tag);
        chk({tag, "_sb_size"}, sb.size(), 32'd1);
        if (sb.size() != 0) begin
            cur = sb.pop_front();
        end
        req_fields(tag);
    endtask

    task automatic done_checks(input string tag);
        chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_rdata"}, mem_rdata, cur.rdata);
        chk({tag, "_rdata0"}, mem_rdata0, cur.rdata);
    endtask

    initial begin
        rst = 1'b1; mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h8000_0104;
        mem_wdata = 32'h0; pipe_advance = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_rdata0", mem_rdata0, 32'h0);

        // Load accepted and completed in the first cycle
        rst = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        push(32'h0000_0104, 32'h8000_0104, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        #1; start_txn("t1");
        tick(); addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'h0; #1;
        done_checks("t1");
        pipe_advance = 1'b1; tick(); pipe_advance = 1'b0; mem_en = 1'b0; #1;
        chk("idle_req", {31'd0, bus_req}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);

        // Store with accept delayed 3 cycles; inputs disturbed to prove latching
        mem_en = 1'b1; mem_wen = 4'b0001; mem_addr = 32'hA000_0013; mem_wdata = 32'h5A5A_5A5A;
        push(32'h0000_0010, 32'hA000_0010, 1'b1, 4'b0001, 32'h5A5A_5A5A, 32'hDEAD_BEEF);
        #1; start_txn("t2_c0");
        for (int i = 1; i < 4; i++) begin
            tick();
            mem_addr = 32'h7777_7770 + i; mem_wdata = 32'h0; mem_wen = 4'b1111;
            if (i == 3) begin
                addr_ok = 1'b1; data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
            end
            #1; req_fields("t2_hold");
        end
        tick(); addr_ok = 1'b0; data_ok = 1'b0; mem_wen = 4'b0000; mem_wdata = 32'h0; #1;
        done_checks("t2");
        pipe_advance = 1'b1; tick(); pipe_advance = 1'b0; mem_en = 1'b0;

        // Load accepted at once, data 5 cycles later
        mem_en = 1'b1; mem_addr = 32'hC000_0044; addr_ok = 1'b1; data_ok = 1'b0;
        push(32'hC000_0044, 32'hC000_0044, 1'b0, 4'b0000, 32'h0, 32'h1234_5678);
        #1; start_txn("t3");
        for (int i = 1; i <= 5; i++) begin
            tick(); addr_ok = 1'b0;
            data_ok = (i == 5);
            bus_rdata = (i == 5) ? 32'h1234_5678 : 32'hBADB_AD00;
            #1;
            chk("t3_wait_req", {31'd0, bus_req}, 32'd0);
            chk("t3_wait_stall", {31'd0, stall}, 32'd1);
        end
        tick(); data_ok = 1'b0; bus_rdata = 32'h0; #1;
        done_checks("t3");

        // DONE held for two cycles without advance: no new request
        tick(); #1;
        chk("t4_hold_req", {31'd0, bus_req}, 32'd0);
        chk("t4_hold_stall", {31'd0, stall}, 32'd0);
        chk("t4_hold_rdata", mem_rdata, 32'h1234_5678);
        pipe_advance = 1'b1; tick(); pipe_advance = 1'b0;
        mem_addr = 32'h8000_0200; addr_ok = 1'b1; data_ok = 1'b0;
        push(32'h0000_0200, 32'h8000_0200, 1'b0, 4'b0000, 32'h0, 32'h0);
        #1; start_txn("t4_next");

        // Reset while in WAIT, then a stray data_ok
        tick(); addr_ok = 1'b0; #1;
        chk("t5_wait_req", {31'd0, bus_req}, 32'd0);
        chk("t5_wait_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1; #1;
        chk("t5_rst_req", {31'd0, bus_req}, 32'd0);
        chk("t5_rst_stall", {31'd0, stall}, 32'd0);
        tick(); rst = 1'b0; mem_en = 1'b0; data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF; #1;
        chk("t5_stray_req", {31'd0, bus_req}, 32'd0);
        chk("t5_stray_stall", {31'd0, stall}, 32'd0);
        chk("t5_after_rst_rdata", mem_rdata, 32'h0);
        tick(); data_ok = 1'b0; bus_rdata = 32'h0; #1;
        chk("t5_rdata", mem_rdata, cur.rdata);
        chk("t5_rdata0", mem_rdata0, cur.rdata);

        // kseg1 boot address with and without mapping
        mem_en = 1'b1; mem_addr = 32'hBFC0_0008; mem_wdata = 32'h1111_2222;
        addr_ok = 1'b1; data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        push(32'h1FC0_0008, 32'hBFC0_0008, 1'b0, 4'b0000, 32'h1111_2222, 32'hCAFE_F00D);
        #1; start_txn("t6");
        tick(); addr_ok = 1'b0; data_ok = 1'b0; #1;
        done_checks("t6");
        pipe_advance = 1'b1; tick(); pipe_advance = 1'b0; mem_en = 1'b0; #1;
        chk("t6_idle_req", {31'd0, bus_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_bridge.md
DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 Parameter: KSEG_MAP, default 1, meaning: 1 enables kseg0/kseg1 physical address mapping on bus_addr.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase does.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 mem_en  in  1  the M-stage instruction is a load or a store.
REQ-006 mem_wen  in  4  byte write strobes from the M stage; 0000 means load.
REQ-007 mem_addr  in  32  byte address (aluoutM).
REQ-008 mem_wdata  in  32  lane-replicated store data.
REQ-009 pipe_advance  in  1  the M stage moves on this cycle (~stallM).
REQ-010 mem_rdata  out  32  load data returned to the M stage (readdataM).
REQ-011 stall_mem  out  1  request to the hazard unit to stall F/D/E/M.
REQ-012 bus_req  out  1  request valid.
REQ-013 bus_wr  out  1  1 means write, 0 means read.
REQ-014 bus_wstrb  out  4  byte strobes.
REQ-015 bus_addr  out  32  word-aligned physical address.
REQ-016 bus_wdata  out  32  write data.
REQ-017 bus_addr_ok  in  1  the slave accepts the request this cycle.
REQ-018 bus_data_ok  in  1  the slave completes the access this cycle.
REQ-019 bus_rdata  in  32  read data, valid when bus_data_ok is high.

Function
REQ-020 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-021 In IDLE with mem_en=1: bus_req=1 combinationally, with request fields driven directly from the mem_* inputs.
REQ-022 On entering REQ, the fields SHALL be latched and driven from the latch.
REQ-023 IDLE transitions: mem_en=1 with addr_ok=1 and data_ok=0 -> WAIT; mem_en=1 with addr_ok=0 -> REQ; mem_en=1 with addr_ok=1 and data_ok=1 -> DONE.
REQ-024 REQ: bus_req held at 1 and fields held stable until bus_addr_ok; transitions -> WAIT, or -> DONE if data_ok arrives in the same cycle.
REQ-025 WAIT: bus_req=0; on bus_data_ok -> DONE.
REQ-026 Any data_ok on a read SHALL capture bus_rdata into the mem_rdata register.
REQ-027 Writes SHALL leave mem_rdata unchanged.
REQ-028 DONE: stall_mem=0 and mem_rdata held; pipe_advance=1 -> IDLE; otherwise remain in DONE and issue no new request.
REQ-029 stall_mem SHALL equal mem_en & (state != DONE), computed combinationally.
REQ-030 Minimum load latency is 2 cycles: stall_mem=1 for exactly 1 cycle when addr_ok and data_ok are asserted together.
REQ-031 bus_wr SHALL equal |mem_wen.
REQ-032 bus_wstrb SHALL equal mem_wen unchanged; byte-lane order is big-endian, so 1000 selects byte address offset 00.
REQ-033 bus_wdata SHALL equal mem_wdata.
REQ-034 bus_addr[1:0] SHALL always be 00.
REQ-035 With KSEG_MAP=1 and mem_addr[31:29] equal to 100 or 101, bus_addr[31:29]=000; all other addresses pass through unchanged.
REQ-036 pipe_advance SHALL be ignored outside DONE.
REQ-037 mem_en SHALL be sampled only in IDLE.
REQ-038 mem_en=0 in IDLE: bus_req=0, stall_mem=0, state unchanged.
REQ-039 Back-to-back accesses SHALL pass through DONE -> IDLE; the next request issues in the cycle after pipe_advance.
REQ-040 At most one transaction SHALL be outstanding at any time.

Reset
REQ-041 rst=1 at a clock edge SHALL force state=IDLE, mem_rdata=0, and clear the latched request fields.
REQ-042 While rst=1: bus_req=0 and stall_mem=0.
REQ-043 Reset mid-transaction (REQ or WAIT) SHALL abandon the transaction; a late bus_data_ok after reset SHALL be ignored.

Verification
REQ-044 Load, mem_addr=0x8000_0104, mem_wen=0; addr_ok and data_ok both asserted in the first cycle with rdata=0xDEAD_BEEF -> bus_addr=0x0000_0104, bus_wr=0, stall_mem high 1 cycle, mem_rdata=0xDEAD_BEEF in DONE.
REQ-045 Store, mem_addr=0xA000_0013, mem_wen=0001, mem_wdata=0x5A5A_5A5A; addr_ok delayed 3 cycles -> bus_req high 4 cycles with fields stable, bus_addr=0x0000_0010, bus_wstrb=0001, mem_rdata unchanged.
REQ-046 Load; addr_ok on cycle 1, data_ok 5 cycles later with rdata=0x1234_5678 -> bus_req=0 during WAIT, stall_mem high until DONE, mem_rdata=0x1234_5678.
REQ-047 DONE with pipe_advance held 0 for 2 cycles, then 1 -> no second bus_req while in DONE; IDLE follows; a new access issues on the next mem_en.
REQ-048 rst pulsed while in WAIT, followed by a stray data_ok with rdata=0xFFFF_FFFF -> state=IDLE, mem_rdata=0, stall_mem=0.
REQ-049 KSEG_MAP=0, mem_addr=0xBFC0_0008 -> bus_addr=0xBFC0_0008.
